// File: rtl/fpu_pkg.sv
// ============================================================================
// Module      : fpu_pkg
// Description : Shared float32 field layout, integer limits and the stage-1
//               register layout used by the float32 -> int32 converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } float32_t;

  localparam logic [7:0]  FP_BIAS   = 8'd127;
  localparam logic [7:0]  FP_EMAX   = 8'd255;
  localparam logic [7:0]  FP_MANT_W = 8'd23;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    CLS_NORM  = 2'd0,
    CLS_SMALL = 2'd1,
    CLS_BIG   = 2'd2,
    CLS_NAN   = 2'd3
  } ftoi_class_e;

  // lsh selects the left-shift path; amt is the shift distance in either direction
  typedef struct packed {
    logic        s;
    logic        lsh;
    logic [4:0]  amt;
    logic [23:0] mant;
    ftoi_class_e cls;
  } ftoi_s1_t;

endpackage

`default_nettype wire

// File: rtl/ftoi_pipe_if.sv
// ============================================================================
// Module      : ftoi_pipe_if
// Description : Operand/result valid-ready bundle of the float32 -> int32
//               converter. slave = converter side, master = producer/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ftoi_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        ovf;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, c, ovf
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, c, ovf
  );
endinterface

`default_nettype wire

// File: rtl/ftoi_pipe_shift_round.sv
// ============================================================================
// Module      : ftoi_shift_round
// Description : Combinational stage 2: shift, round, negate and overflow
//               mapping. Macro FTOI_SAT_EN selects saturating overflow values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftoi_shift_round
  import fpu_pkg::*;
#(
  parameter bit ROUND_TRUNC = 1'b0
) (
  input  ftoi_s1_t    i_op,
  output logic [31:0] o_c,
  output logic        o_ovf
);

  logic [31:0] w_lmag;
  logic [24:0] w_rsh;
  logic        w_guard;
  logic [32:0] w_mag;
  logic        w_rnd_ovf;
  logic [31:0] w_sat;

  always_comb begin
    w_lmag  = {8'd0, i_op.mant} << i_op.amt;
    // Extra low bit catches the last bit shifted out as the guard
    w_rsh   = {i_op.mant, 1'b0} >> i_op.amt;
    w_guard = !i_op.lsh && w_rsh[0];
    w_mag   = {1'b0, (i_op.lsh ? w_lmag : {8'd0, w_rsh[24:1]})};
    if (!ROUND_TRUNC && w_guard) begin
      w_mag = w_mag + 33'd1;
    end
    w_rnd_ovf = i_op.s ? (w_mag > {1'b0, INT32_MIN}) : (w_mag[32] || w_mag[31]);
  end

`ifdef FTOI_SAT_EN
  logic w_is_nan;
  assign w_is_nan = (i_op.cls == CLS_NAN) && (i_op.mant[22:0] != 23'd0);
  assign w_sat    = (w_is_nan || !i_op.s) ? INT32_MAX : INT32_MIN;
`else
  assign w_sat    = INT32_MIN;
`endif

  always_comb begin
    o_c   = 32'd0;
    o_ovf = 1'b0;
    case (i_op.cls)
      CLS_SMALL: o_c = 32'd0;
      CLS_NORM: begin
        if (w_rnd_ovf) begin
          o_ovf = 1'b1;
        end else begin
          o_c = i_op.s ? (~w_mag[31:0] + 32'd1) : w_mag[31:0];
        end
      end
      default:   o_ovf = 1'b1;
    endcase
    if (o_ovf) begin
      o_c = w_sat;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ftoi_pipe.sv
// ============================================================================
// Module      : ftoi_pipe
// Description : Two-stage pipelined float32 -> int32 converter, valid/ready.
//               Optional macro FTOI_SAT_EN: saturating overflow results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter bit ROUND_TRUNC = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  ftoi_pipe_if.slave bus
);

  localparam logic [7:0] c_E_INT_LSB = FP_BIAS + FP_MANT_W;
  localparam logic [7:0] c_E_BIG     = FP_BIAS + 8'd31;
  localparam logic [7:0] c_E_SMALL   = ROUND_TRUNC ? FP_BIAS : (FP_BIAS - 8'd1);

  float32_t    w_a;
  ftoi_s1_t    w_s1_d;
  ftoi_s1_t    r_s1;
  logic        r_s1_v;
  logic        r_s2_v;
  logic [31:0] r_c;
  logic        r_ovf;
  logic [31:0] w_c;
  logic        w_ovf;
  logic        w_s2_adv;
  logic        w_in_ready;

  assign w_a = bus.a;

  always_comb begin
    w_s1_d.s    = w_a.s;
    w_s1_d.lsh  = (w_a.e >= c_E_INT_LSB);
    w_s1_d.amt  = w_s1_d.lsh ? 5'(w_a.e - c_E_INT_LSB) : 5'(c_E_INT_LSB - w_a.e);
    w_s1_d.mant = {1'b1, w_a.m};
    if (w_a.e == FP_EMAX) begin
      w_s1_d.cls = CLS_NAN;
    end else if (w_a.e >= c_E_BIG) begin
      // -2^31 is the only operand at this exponent that still fits
      w_s1_d.cls = (bus.a == 32'hCF00_0000) ? CLS_NORM : CLS_BIG;
    end else if (w_a.e < c_E_SMALL) begin
      w_s1_d.cls = CLS_SMALL;
    end else begin
      w_s1_d.cls = CLS_NORM;
    end
  end

  assign w_s2_adv   = !r_s2_v || bus.out_ready;
  assign w_in_ready = !r_s1_v || w_s2_adv;

  ftoi_shift_round #(
    .ROUND_TRUNC (ROUND_TRUNC)
  ) u_shift_round (
    .i_op  (r_s1),
    .o_c   (w_c),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
      r_s2_v <= 1'b0;
      r_c    <= 32'd0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_v <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1 <= w_s1_d;
        end
      end
      if (w_s2_adv) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_c   <= w_c;
          r_ovf <= w_ovf;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_v;
  assign bus.c         = r_c;
  assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire
